// File: rtl/axis_frame_gen_pkg.sv
// axis_frame_gen_pkg: shared state enum, LFSR constants and last-beat tkeep helper for axis_frame_gen
package axis_frame_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;
  // Right-shift Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
  localparam int MAX_KEEP = 128;
  // Low rem bits set; a zero remainder means the last beat is full
  function automatic logic [MAX_KEEP-1:0] last_keep(input int rem, input int kw);
    logic [MAX_KEEP-1:0] k;
    for (int i = 0; i < MAX_KEEP; i++) k[i] = i < ((rem == 0) ? kw : rem);
    return k;
  endfunction
endpackage

// File: rtl/axis_frame_gen_pattern.sv
// axis_frame_gen_pattern: combinational tdata generator for axis_frame_gen
// Ports: keep (lane enables), data (beat payload, disabled lanes forced to 0);
// default build takes frame (low 8 bits of frame index) and beat (beat index);
// with AXIS_FRAME_GEN_LFSR_EN defined it takes lfsr (current LFSR state) instead.
module axis_frame_gen_pattern
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
) (
`ifdef AXIS_FRAME_GEN_LFSR_EN
  input  logic [31:0]           lfsr,
`else
  input  logic [7:0]            frame,
  input  logic [LEN_WIDTH-1:0]  beat,
`endif
  input  logic [KEEP_WIDTH-1:0] keep,
  output logic [DATA_WIDTH-1:0] data
);
  always_comb begin
    data = '0;
    for (int i = 0; i < KEEP_WIDTH; i++)
`ifdef AXIS_FRAME_GEN_LFSR_EN
      data[8*i +: 8] = keep[i] ? lfsr[8*(i%4) +: 8] : 8'h00;
`else
      data[8*i +: 8] = keep[i] ? frame + 8'(beat * KEEP_WIDTH + i) : 8'h00;
`endif
  end
endmodule

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream test frame transmitter with length/count/gap control
// Ports: clk, rst (async active-high); start/stop run control; cfg_len, cfg_count,
// cfg_gap, cfg_bad latched at start; busy, done, frames_sent status;
// m_axis_* AXI-Stream master. Define AXIS_FRAME_GEN_LFSR_EN for LFSR payload data.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic                  cfg_bad,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);
  state_t state, state_n;
  logic [LEN_WIDTH-1:0] beat, last_beat;
  logic [KEEP_WIDTH-1:0] keep_last, keep;
  logic [CNT_WIDTH-1:0] count;
  logic [GAP_WIDTH-1:0] gap, gap_cnt;
  logic bad, stop_seen, accept, fire, is_last, halt;
  assign accept = state == IDLE && start && cfg_len != '0;
  assign is_last = beat == last_beat;
  assign fire = m_axis_tvalid && m_axis_tready;
  assign halt = stop || stop_seen;
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tlast = m_axis_tvalid && is_last;
  assign keep = m_axis_tvalid ? (is_last ? keep_last : '1) : '0;
  assign m_axis_tkeep = keep;
  assign m_axis_tuser = USER_WIDTH'(m_axis_tlast && bad);
  assign done = state == FINISH;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? SEND : IDLE;
      SEND:    if (fire && is_last)
                 state_n = ((count != '0 && frames_sent + 1'b1 == count) || halt) ? FINISH :
                           (gap != '0) ? GAP : SEND;
      GAP:     state_n = halt ? FINISH : (gap_cnt == gap - 1'b1) ? SEND : GAP;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frames_sent <= '0;
      beat        <= '0;
      last_beat   <= '0;
      keep_last   <= '0;
      count       <= '0;
      gap         <= '0;
      gap_cnt     <= '0;
      bad         <= 1'b0;
      stop_seen   <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        busy        <= 1'b1;
        frames_sent <= '0;
        beat        <= '0;
        stop_seen   <= 1'b0;
        last_beat   <= LEN_WIDTH'((cfg_len - 1'b1) / KEEP_WIDTH);
        keep_last   <= KEEP_WIDTH'(last_keep(int'(cfg_len % KEEP_WIDTH), KEEP_WIDTH));
        count       <= cfg_count;
        gap         <= cfg_gap;
        bad         <= cfg_bad;
      end else begin
        if (state == FINISH) busy <= 1'b0;
        if (stop && state != IDLE) stop_seen <= 1'b1;
        if (fire) begin
          beat <= is_last ? '0 : beat + 1'b1;
          if (is_last) frames_sent <= frames_sent + 1'b1;
        end
      end
    end
`ifdef AXIS_FRAME_GEN_LFSR_EN
  logic [31:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= '0;
    else if (accept) lfsr <= LFSR_SEED;
    else if (fire) lfsr <= is_last ? LFSR_SEED + 32'(frames_sent) + 32'd1
                                   : {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
`endif
  axis_frame_gen_pattern #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_pattern (
`ifdef AXIS_FRAME_GEN_LFSR_EN
    .lfsr (lfsr),
`else
    .frame(8'(frames_sent)),
    .beat (beat),
`endif
    .keep (keep),
    .data (m_axis_tdata)
  );
endmodule

// File: tb/tb_axis_frame_gen.sv
// tb_axis_frame_gen: directed self-checking bench for axis_frame_gen
module tb_axis_frame_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_bad = 1'b0, tready = 1'b0;
  logic [15:0] cfg_len = '0, cfg_count = '0, frames_sent;
  logic [7:0] cfg_gap = '0;
  logic busy, done, tvalid, tlast;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic [0:0] tuser;
  int passed = 0, fails = 0, total = 0, cyc = 0, nb = 0;
  logic [31:0] cap_data [32];
  logic [3:0] cap_keep [32];
  logic cap_last [32], cap_user [32];
  int cap_cyc [32];
  logic [31:0] e1d [6] = '{32'h03020100, 32'h07060504, 32'h00000908, 32'h04030201, 32'h08070605, 32'h00000A09};
  logic [3:0] e1k [6] = '{4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'h3};
  logic [31:0] e3d [6] = '{32'h03020100, 32'h00000004, 32'h04030201, 32'h00000005, 32'h05040302, 32'h00000006};

  always #5 clk = ~clk;

  axis_frame_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_len(cfg_len), .cfg_count(cfg_count),
    .cfg_gap(cfg_gap), .cfg_bad(cfg_bad), .busy(busy), .done(done), .frames_sent(frames_sent),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic collect(input int n, input bit toggle);
    int t = 0, got = 0;
    bit stalled = 0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    while (got < n && t < 200) begin
      tready = toggle ? t[0] : 1'b1;
      if (stalled) begin
        check("stall_data", tdata, hd);
        check("stall_last", tlast, hl);
      end
      stalled = tvalid && !tready;
      hd = tdata;
      hl = tlast;
      if (tvalid && tready) begin
        cap_data[nb] = tdata; cap_keep[nb] = tkeep; cap_last[nb] = tlast;
        cap_user[nb] = tuser[0]; cap_cyc[nb] = cyc;
        nb++; got++;
      end
      tick();
      t++;
    end
    check("collect_beats", got, n);
  endtask

  task automatic go(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap, input logic bad);
    cfg_len = len; cfg_count = cnt; cfg_gap = gap; cfg_bad = bad; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
  endtask

  initial begin
    tick(); tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_tdata", tdata, 0);
    rst = 1'b0;
    tick();
    // two back-to-back 10-byte frames
    check("t1_pre_tvalid", tvalid, 0);
    go(16'd10, 16'd2, 8'd0, 1'b0);
    check("t1_busy", busy, 1);
    check("t1_tvalid", tvalid, 1);
    collect(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_data%0d", i), cap_data[i], e1d[i]);
      check($sformatf("t1_keep%0d", i), cap_keep[i], e1k[i]);
      check($sformatf("t1_last%0d", i), cap_last[i], (i == 2 || i == 5));
    end
    check("t1_b2b", cap_cyc[3] - cap_cyc[2], 1);
    check("t1_done", done, 1);
    check("t1_frames", frames_sent, 2);
    tick();
    check("t1_done_off", done, 0);
    check("t1_busy_off", busy, 0);
    // backpressure toggling
    go(16'd8, 16'd1, 8'd0, 1'b0);
    collect(2, 1'b1);
    check("t2_data0", cap_data[0], 32'h03020100);
    check("t2_data1", cap_data[1], 32'h07060504);
    check("t2_last0", cap_last[0], 0);
    check("t2_last1", cap_last[1], 1);
    check("t2_keep1", cap_keep[1], 4'hF);
    check("t2_done", done, 1);
    tick();
    // gap of 4 with bad-frame marking
    go(16'd5, 16'd3, 8'd4, 1'b1);
    collect(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_data%0d", i), cap_data[i], e3d[i]);
      check($sformatf("t3_keep%0d", i), cap_keep[i], i[0] ? 4'h1 : 4'hF);
      check($sformatf("t3_user%0d", i), cap_user[i], i[0]);
    end
    check("t3_gap01", cap_cyc[2] - cap_cyc[1] - 1, 4);
    check("t3_gap12", cap_cyc[4] - cap_cyc[3] - 1, 4);
    check("t3_done", done, 1);
    check("t3_frames", frames_sent, 3);
    tick();
    // continuous run stopped in the middle of frame 2
    go(16'd6, 16'd0, 8'd0, 1'b0);
    collect(5, 1'b0);
    tready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_mid_tvalid", tvalid, 1);
    collect(1, 1'b0);
    check("t4_f0b1", cap_data[1], 32'h00000504);
    check("t4_f2b0", cap_data[4], 32'h05040302);
    check("t4_data", cap_data[5], 32'h00000706);
    check("t4_keep", cap_keep[5], 4'h3);
    check("t4_last", cap_last[5], 1);
    check("t4_done", done, 1);
    check("t4_frames", frames_sent, 3);
    tick();
    check("t4_busy_off", busy, 0);
    // zero length ignored; start while busy ignored
    go(16'd0, 16'd1, 8'd0, 1'b0);
    check("t5_busy", busy, 0);
    check("t5_tvalid", tvalid, 0);
    tick();
    check("t5_tvalid2", tvalid, 0);
    go(16'd4, 16'd1, 8'd0, 1'b0);
    tready = 1'b0;
    cfg_len = 16'd12; cfg_count = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    collect(1, 1'b0);
    check("t5_data", cap_data[0], 32'h03020100);
    check("t5_last", cap_last[0], 1);
    check("t5_done", done, 1);
    check("t5_frames", frames_sent, 1);
    tick();
    check("t5_idle_tvalid", tvalid, 0);
    check("t5_idle_busy", busy, 0);
    // asynchronous reset mid-frame
    go(16'd4, 16'd0, 8'd0, 1'b0);
    collect(2, 1'b0);
    tready = 1'b0;
    check("t6_pre_frames", frames_sent, 2);
    #2 rst = 1'b1;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_frames", frames_sent, 0);
    tick();
    rst = 1'b0;
    tick();
    go(16'd4, 16'd1, 8'd0, 1'b0);
    collect(1, 1'b0);
    check("t6_data", cap_data[0], 32'h03020100);
    check("t6_done", done, 1);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
